// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width: just enough to count 0..WIDTH-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for the serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_full_add_bit.sv
// One-bit full adder built from gate primitives (xor/xor sum, and/and/or carry).
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic t, g, p;

  xor x0 (t, a, b);
  xor x1 (s, t, cin);
  and a0 (g, a, b);
  and a1 (p, t, cin);
  or  o0 (co, g, p);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry FF, LSB first, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic [WIDTH-1:0] sum_q;
  logic             carry, cout_q, done_q;
  logic [CW-1:0]    cnt;
  logic             s, co;
  logic             accept, last;

  full_add_bit u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .s   (s),
    .co  (co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; start is only honoured when not in RUN.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        accept  = bus.start;
        state_d = bus.start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_sr  <= bus.a;
        b_sr  <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
      end else if (state_q == RUN) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        acc   <= {s, acc[WIDTH-1:1]};
        carry <= co;
        // Counter wraps to 0 on the last bit so it never exceeds WIDTH-1.
        cnt   <= last ? '0 : cnt + CW'(1);
        if (last) begin
          sum_q  <= {s, acc[WIDTH-1:1]};
          cout_q <= co;
        end
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive an operation so it is accepted on the next rising edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = ci;
    @(posedge clk);
  endtask

  // Observe n cycles after the accepting edge (sample i follows edge E_i).
  task automatic observe(input int n, output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0;
        bus.a     = 8'hC3;
        bus.b     = 8'h3C;
        bus.cin   = 1'b1;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int bn, dn, da;
    launch(8'h35, 8'h4A, 1'b0);
    observe(12, bn, dn, da);
    checks++; if (bn !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bn); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", dn); end
    checks++; if (da !== W) begin errors++; $display("FAIL basic_done_latency got=%0d exp=%0d", da, W); end
    checks++; if (bus.sum !== 8'h7F) begin errors++; $display("FAIL basic_sum got=%h exp=7f", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", bus.cout); end
  endtask

  task automatic test_carry_ripple;
    int bn, dn, da;
    launch(8'hFF, 8'h01, 1'b0);
    observe(12, bn, dn, da);
    checks++; if (dn !== 1) begin errors++; $display("FAIL ripple_done_pulses got=%0d exp=1", dn); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL ripple_sum got=%h exp=00", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("FAIL ripple_cout got=%b exp=1", bus.cout); end
  endtask

  task automatic test_max_cin;
    int bn, dn, da;
    launch(8'hFF, 8'hFF, 1'b1);
    observe(12, bn, dn, da);
    checks++; if (bus.sum !== 8'hFF) begin errors++; $display("FAIL maxcin_sum got=%h exp=ff", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("FAIL maxcin_cout got=%b exp=1", bus.cout); end
  endtask

  task automatic test_start_while_busy;
    int dn = 0;
    launch(8'h10, 8'h20, 1'b0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (i == 3) begin bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1; end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) dn++;
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL busy_start_done_pulses got=%0d exp=1", dn); end
    checks++; if (bus.sum !== 8'h30) begin errors++; $display("FAIL busy_start_sum got=%h exp=30", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL busy_start_cout got=%b exp=0", bus.cout); end
  endtask

  task automatic test_reset_mid_op;
    int bn, dn, da;
    launch(8'h0F, 8'h0F, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL midrst_sum got=%h exp=00", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", bus.cout); end
    @(negedge clk);
    rst = 1'b0;
    launch(8'h01, 8'h02, 1'b0);
    observe(12, bn, dn, da);
    checks++; if (dn !== 1) begin errors++; $display("FAIL midrst_after_done got=%0d exp=1", dn); end
    checks++; if (bus.sum !== 8'h03) begin errors++; $display("FAIL midrst_after_sum got=%h exp=03", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL midrst_after_cout got=%b exp=0", bus.cout); end
  endtask

  task automatic test_back_to_back;
    int hold_bad = 0;
    int dn = 0;
    logic d1, c1, d2, c2, b9;
    logic [W-1:0] s1, s2;
    launch(8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      // Second operand set is presented while the first is running; start stays high.
      if (i == 0) begin bus.a = 8'h03; bus.b = 8'h04; bus.cin = 1'b1; end
      if (bus.done) dn++;
      if (i == W)         begin d1 = bus.done; s1 = bus.sum; c1 = bus.cout; end
      if (i == W + 1)     begin b9 = bus.busy; bus.start = 1'b0; end
      if (i > W && i < 2 * W + 1 && bus.sum !== 8'h00) hold_bad++;
      if (i == 2 * W + 1) begin d2 = bus.done; s2 = bus.sum; c2 = bus.cout; end
    end
    checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", d1); end
    checks++; if (s1 !== 8'h00 || c1 !== 1'b1) begin errors++; $display("FAIL b2b_first_result got=%b_%h exp=1_00", c1, s1); end
    checks++; if (b9 !== 1'b1) begin errors++; $display("FAIL b2b_no_idle_gap busy=%b exp=1", b9); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL b2b_sum_hold bad_cycles=%0d exp=0", hold_bad); end
    checks++; if (d2 !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", d2); end
    checks++; if (s2 !== 8'h08 || c2 !== 1'b0) begin errors++; $display("FAIL b2b_second_result got=%b_%h exp=0_08", c2, s2); end
    checks++; if (dn !== 2) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=2", dn); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry_ripple;
    test_max_cin;
    test_start_while_busy;
    test_reset_mid_op;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
